// File: rtl/apb_node_decoder.sv
// APB 1-to-N node with parameter address map, decode-error response and access watchdog.
// Every upstream and downstream output is driven from a register.

module apb_node_decoder #(
    parameter int                       NB_SLV     = 14,
    parameter int                       ADDR_W     = 32,
    parameter int                       DATA_W     = 32,
    parameter logic [NB_SLV*ADDR_W-1:0] START_ADDR = '0,
    parameter logic [NB_SLV*ADDR_W-1:0] END_ADDR   = '0,
    parameter int                       TIMEOUT    = 255,
    parameter logic [DATA_W-1:0]        ERR_DATA   = DATA_W'(32'hBADA_CCE5)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        s_paddr,
    input  logic [DATA_W-1:0]        s_pwdata,
    input  logic                     s_pwrite,
    input  logic                     s_psel,
    input  logic                     s_penable,
    output logic [DATA_W-1:0]        s_prdata,
    output logic                     s_pready,
    output logic                     s_pslverr,
    output logic [ADDR_W-1:0]        m_paddr,
    output logic [DATA_W-1:0]        m_pwdata,
    output logic                     m_pwrite,
    output logic [NB_SLV-1:0]        m_psel,
    output logic                     m_penable,
    input  logic [NB_SLV*DATA_W-1:0] m_prdata,
    input  logic [NB_SLV-1:0]        m_pready,
    input  logic [NB_SLV-1:0]        m_pslverr,
    output logic                     err_o,
    output logic [1:0]               err_code_o,
    output logic [ADDR_W-1:0]        err_addr_o
);

    // state  | meaning
    // IDLE   | waiting for s_psel; latches request and decodes
    // SETUP  | m_psel[idx]=1, m_penable=0
    // ACCESS | m_penable=1, waiting on m_pready[idx] or watchdog
    // RESP   | one-cycle s_pready to upstream, downstream released
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int IDX_W = (NB_SLV > 1) ? $clog2(NB_SLV) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] CODE_MISS    = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;
    localparam logic [1:0] CODE_SLVERR  = 2'b11;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;

    logic [ADDR_W-1:0]   paddr_d;
    logic [DATA_W-1:0]   pwdata_d;
    logic                pwrite_d;
    logic [NB_SLV-1:0]   psel_d;
    logic                penable_d;
    logic [DATA_W-1:0]   prdata_d;
    logic                pready_d;
    logic                pslverr_d;
    logic                err_d;
    logic [1:0]          err_code_d;
    logic [ADDR_W-1:0]   err_addr_d;

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic [DATA_W-1:0]   sel_rdata;
    logic                sel_ready;
    logic                sel_err;
    logic                wd_expire;

    // Upstream enable carries no information for this node; requests start on s_psel alone.
    logic unused_penable;
    assign unused_penable = s_penable;

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NB_SLV - 1; i >= 0; i--) begin
            if ((s_paddr >= START_ADDR[i*ADDR_W +: ADDR_W]) &&
                (s_paddr <= END_ADDR[i*ADDR_W +: ADDR_W])) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        for (int i = 0; i < NB_SLV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_rdata = m_prdata[i*DATA_W +: DATA_W];
                sel_ready = m_pready[i];
                sel_err   = m_pslverr[i];
            end
        end
    end

    assign wd_expire = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wd_cnt_d   = wd_cnt_q;
        paddr_d    = m_paddr;
        pwdata_d   = m_pwdata;
        pwrite_d   = m_pwrite;
        psel_d     = m_psel;
        penable_d  = m_penable;
        prdata_d   = s_prdata;
        pready_d   = s_pready;
        pslverr_d  = s_pslverr;
        err_d      = err_o;
        err_code_d = err_code_o;
        err_addr_d = err_addr_o;

        case (state_q)
            IDLE: begin
                if (s_psel) begin
                    paddr_d  = s_paddr;
                    pwdata_d = s_pwdata;
                    pwrite_d = s_pwrite;
                    if (hit) begin
                        idx_d   = hit_idx;
                        state_d = SETUP;
                        for (int i = 0; i < NB_SLV; i++) begin
                            psel_d[i] = (hit_idx == IDX_W'(i));
                        end
                    end else begin
                        state_d    = RESP;
                        prdata_d   = ERR_DATA;
                        pready_d   = 1'b1;
                        pslverr_d  = 1'b1;
                        err_d      = 1'b1;
                        err_code_d = CODE_MISS;
                        err_addr_d = s_paddr;
                    end
                end
            end

            SETUP: begin
                penable_d = 1'b1;
                wd_cnt_d  = '0;
                state_d   = ACCESS;
            end

            ACCESS: begin
                // A ready arriving in the final watchdog cycle still completes normally.
                if (sel_ready) begin
                    state_d   = RESP;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    prdata_d  = sel_rdata;
                    pready_d  = 1'b1;
                    pslverr_d = sel_err;
                    if (sel_err) begin
                        err_d      = 1'b1;
                        err_code_d = CODE_SLVERR;
                        err_addr_d = m_paddr;
                    end
                end else if (wd_expire) begin
                    state_d    = RESP;
                    psel_d     = '0;
                    penable_d  = 1'b0;
                    prdata_d   = ERR_DATA;
                    pready_d   = 1'b1;
                    pslverr_d  = 1'b1;
                    err_d      = 1'b1;
                    err_code_d = CODE_TIMEOUT;
                    err_addr_d = m_paddr;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end

            RESP: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                err_d     = 1'b0;
                state_d   = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            wd_cnt_q   <= '0;
            m_paddr    <= '0;
            m_pwdata   <= '0;
            m_pwrite   <= 1'b0;
            m_psel     <= '0;
            m_penable  <= 1'b0;
            s_prdata   <= '0;
            s_pready   <= 1'b0;
            s_pslverr  <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= '0;
            err_addr_o <= '0;
        end else begin
            idx_q      <= idx_d;
            wd_cnt_q   <= wd_cnt_d;
            m_paddr    <= paddr_d;
            m_pwdata   <= pwdata_d;
            m_pwrite   <= pwrite_d;
            m_psel     <= psel_d;
            m_penable  <= penable_d;
            s_prdata   <= prdata_d;
            s_pready   <= pready_d;
            s_pslverr  <= pslverr_d;
            err_o      <= err_d;
            err_code_o <= err_code_d;
            err_addr_o <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_apb_node_decoder.sv
// Directed bench for apb_node_decoder: 14 ports at 4 KiB strides from 1A10_0000,
// port2 stretched over ports 3..5, watchdog of 4 ACCESS cycles.

module tb_apb_node_decoder;

    localparam int NB = 14;
    localparam int AW = 32;
    localparam int DW = 32;

    function automatic logic [NB*AW-1:0] mk_map(input bit is_end);
        logic [NB*AW-1:0] v;
        v = '0;
        for (int i = 0; i < NB; i++) begin
            v[i*AW +: AW] = 32'h1A10_0000 + (32'(i) << 12) + (is_end ? 32'h0000_0FFF : 32'h0);
        end
        if (is_end) v[2*AW +: AW] = 32'h1A10_5FFF;
        return v;
    endfunction

    localparam logic [NB*AW-1:0] MAP_START = mk_map(1'b0);
    localparam logic [NB*AW-1:0] MAP_END   = mk_map(1'b1);

    logic            clk;
    logic            rst;
    logic [AW-1:0]   s_paddr;
    logic [DW-1:0]   s_pwdata;
    logic            s_pwrite;
    logic            s_psel;
    logic            s_penable;
    logic [DW-1:0]   s_prdata;
    logic            s_pready;
    logic            s_pslverr;
    logic [AW-1:0]   m_paddr;
    logic [DW-1:0]   m_pwdata;
    logic            m_pwrite;
    logic [NB-1:0]   m_psel;
    logic            m_penable;
    logic [NB*DW-1:0] m_prdata;
    logic [NB-1:0]   m_pready;
    logic [NB-1:0]   m_pslverr;
    logic            err_o;
    logic [1:0]      err_code_o;
    logic [AW-1:0]   err_addr_o;

    apb_node_decoder #(
        .NB_SLV     (NB),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .START_ADDR (MAP_START),
        .END_ADDR   (MAP_END),
        .TIMEOUT    (4),
        .ERR_DATA   (32'hBADA_CCE5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_paddr    (s_paddr),
        .s_pwdata   (s_pwdata),
        .s_pwrite   (s_pwrite),
        .s_psel     (s_psel),
        .s_penable  (s_penable),
        .s_prdata   (s_prdata),
        .s_pready   (s_pready),
        .s_pslverr  (s_pslverr),
        .m_paddr    (m_paddr),
        .m_pwdata   (m_pwdata),
        .m_pwrite   (m_pwrite),
        .m_psel     (m_psel),
        .m_penable  (m_penable),
        .m_prdata   (m_prdata),
        .m_pready   (m_pready),
        .m_pslverr  (m_pslverr),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .err_addr_o (err_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int          r_lat, r_acc, r_errp;
    logic [31:0] r_psel, r_rdata, r_paddr, r_pwdata, r_eaddr;
    logic        r_pwrite, r_slverr, r_after_rdy, r_after_err;
    logic [1:0]  r_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Upstream master plus a reactive downstream slave: ready after `waits` extra ACCESS cycles.
    task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input bit wr,
                        input int port, input int waits, input bit never,
                        input logic [31:0] rdata, input bit perr);
        bit seen_sel;
        seen_sel = 1'b0;
        for (int i = 0; i < NB; i++) begin
            m_prdata[i*DW +: DW] = (i == port) ? rdata : (32'hDEAD_0000 | 32'(i));
        end
        m_pslverr = '1;
        if (port >= 0) m_pslverr[port] = perr;
        m_pready  = '0;
        r_lat = -1; r_acc = 0; r_errp = 0; r_psel = '0;
        r_rdata = '0; r_paddr = '0; r_pwdata = '0; r_pwrite = 1'b0;
        r_slverr = 1'b0; r_code = '0; r_eaddr = '0;
        s_paddr   = addr;
        s_pwdata  = wdata;
        s_pwrite  = wr;
        s_psel    = 1'b1;
        s_penable = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            step();
            s_penable = 1'b1;
            r_psel |= 32'(m_psel);
            if (!seen_sel && m_psel != '0) begin
                seen_sel = 1'b1;
                r_paddr  = m_paddr;
                r_pwdata = m_pwdata;
                r_pwrite = m_pwrite;
            end
            r_errp += int'(err_o);
            if (m_penable && m_psel != '0) r_acc++;
            if (s_pready) begin
                r_lat    = n;
                r_rdata  = s_prdata;
                r_slverr = s_pslverr;
                r_code   = err_code_o;
                r_eaddr  = err_addr_o;
                break;
            end
            m_pready = (m_penable && !never && r_acc > waits) ? m_psel : '0;
        end
        s_psel    = 1'b0;
        s_penable = 1'b0;
        m_pready  = '0;
        step();
        r_after_rdy = s_pready;
        r_after_err = err_o;
    endtask

    initial begin
        rst = 1'b1;
        s_paddr = '0; s_pwdata = '0; s_pwrite = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
        m_prdata = '0; m_pready = '0; m_pslverr = '0;
        step();
        step();
        chk("rst_s_pready",   32'(s_pready),   32'h0);
        chk("rst_s_prdata",   s_prdata,        32'h0);
        chk("rst_s_pslverr",  32'(s_pslverr),  32'h0);
        chk("rst_m_psel",     32'(m_psel),     32'h0);
        chk("rst_m_penable",  32'(m_penable),  32'h0);
        chk("rst_m_paddr",    m_paddr,         32'h0);
        chk("rst_err_o",      32'(err_o),      32'h0);
        chk("rst_err_code",   32'(err_code_o), 32'h0);
        chk("rst_err_addr",   err_addr_o,      32'h0);
        rst = 1'b0;

        // Zero-wait read from port13.
        xfer(32'h1A10_D004, 32'h0, 1'b0, 13, 0, 1'b0, 32'h1234_5678, 1'b0);
        chk("rd13_latency", 32'(r_lat),      32'd3);
        chk("rd13_psel",    r_psel,          32'h0000_2000);
        chk("rd13_paddr",   r_paddr,         32'h1A10_D004);
        chk("rd13_prdata",  r_rdata,         32'h1234_5678);
        chk("rd13_pslverr", 32'(r_slverr),   32'h0);
        chk("rd13_errp",    32'(r_errp),     32'h0);
        chk("rd13_oneshot", 32'(r_after_rdy), 32'h0);

        // Write to port0 with two wait states.
        xfer(32'h1A10_0010, 32'hCAFE_F00D, 1'b1, 0, 2, 1'b0, 32'h0000_0A0A, 1'b0);
        chk("wr0_latency", 32'(r_lat),    32'd5);
        chk("wr0_psel",    r_psel,        32'h0000_0001);
        chk("wr0_pwdata",  r_pwdata,      32'hCAFE_F00D);
        chk("wr0_pwrite",  32'(r_pwrite), 32'h1);
        chk("wr0_access",  32'(r_acc),    32'd3);
        chk("wr0_errp",    32'(r_errp),   32'h0);

        // Unmapped read.
        xfer(32'h2000_0000, 32'h0, 1'b0, -1, 0, 1'b0, 32'h0, 1'b0);
        chk("miss_latency", 32'(r_lat),       32'd1);
        chk("miss_psel",    r_psel,           32'h0);
        chk("miss_prdata",  r_rdata,          32'hBADA_CCE5);
        chk("miss_pslverr", 32'(r_slverr),    32'h1);
        chk("miss_code",    32'(r_code),      32'h1);
        chk("miss_addr",    r_eaddr,          32'h2000_0000);
        chk("miss_errp",    32'(r_errp),      32'd1);
        chk("miss_err_end", 32'(r_after_err), 32'h0);

        // Hung slave on port7: four ACCESS cycles then abort.
        xfer(32'h1A10_7000, 32'h0, 1'b0, 7, 0, 1'b1, 32'h7777_7777, 1'b0);
        chk("tmo_latency", 32'(r_lat),    32'd6);
        chk("tmo_access",  32'(r_acc),    32'd4);
        chk("tmo_psel",    r_psel,        32'h0000_0080);
        chk("tmo_prdata",  r_rdata,       32'hBADA_CCE5);
        chk("tmo_pslverr", 32'(r_slverr), 32'h1);
        chk("tmo_code",    32'(r_code),   32'h2);
        chk("tmo_addr",    r_eaddr,       32'h1A10_7000);
        chk("tmo_errp",    32'(r_errp),   32'd1);

        // Ready in the last watchdog cycle completes normally; error sideband keeps old value.
        xfer(32'h1A10_8000, 32'h0, 1'b0, 8, 3, 1'b0, 32'h0000_8888, 1'b0);
        chk("edge_latency", 32'(r_lat),    32'd6);
        chk("edge_prdata",  r_rdata,       32'h0000_8888);
        chk("edge_pslverr", 32'(r_slverr), 32'h0);
        chk("edge_errp",    32'(r_errp),   32'h0);
        chk("edge_code",    32'(r_code),   32'h2);
        chk("edge_addr",    r_eaddr,       32'h1A10_7000);

        // Slave error on port9 with one wait state.
        xfer(32'h1A10_9ABC, 32'h0, 1'b0, 9, 1, 1'b0, 32'h5555_AAAA, 1'b1);
        chk("slv_latency", 32'(r_lat),    32'd4);
        chk("slv_prdata",  r_rdata,       32'h5555_AAAA);
        chk("slv_pslverr", 32'(r_slverr), 32'h1);
        chk("slv_code",    32'(r_code),   32'h3);
        chk("slv_addr",    r_eaddr,       32'h1A10_9ABC);
        chk("slv_errp",    32'(r_errp),   32'd1);

        // Overlap: 1A10_5008 lies in port2 and port5, port2 wins.
        xfer(32'h1A10_5008, 32'h0, 1'b0, 2, 0, 1'b0, 32'h2222_5555, 1'b0);
        chk("ovl_psel",    r_psel,        32'h0000_0004);
        chk("ovl_latency", 32'(r_lat),    32'd3);
        chk("ovl_prdata",  r_rdata,       32'h2222_5555);
        chk("ovl_pslverr", 32'(r_slverr), 32'h0);

        // Reset asserted while in ACCESS on port10.
        m_pready  = '0;
        s_paddr   = 32'h1A10_A000;
        s_pwrite  = 1'b0;
        s_psel    = 1'b1;
        s_penable = 1'b0;
        step();
        s_penable = 1'b1;
        step();
        chk("mid_in_access", 32'(m_penable), 32'h1);
        rst = 1'b1;
        step();
        chk("mid_rst_psel",    32'(m_psel),    32'h0);
        chk("mid_rst_penable", 32'(m_penable), 32'h0);
        chk("mid_rst_pready",  32'(s_pready),  32'h0);
        rst       = 1'b0;
        s_psel    = 1'b0;
        s_penable = 1'b0;
        step();
        chk("mid_idle_pready", 32'(s_pready), 32'h0);
        chk("mid_idle_psel",   32'(m_psel),   32'h0);

        xfer(32'h1A10_1040, 32'h0, 1'b0, 1, 0, 1'b0, 32'h0101_0101, 1'b0);
        chk("post_latency", 32'(r_lat),    32'd3);
        chk("post_psel",    r_psel,        32'h0000_0002);
        chk("post_prdata",  r_rdata,       32'h0101_0101);
        chk("post_pslverr", 32'(r_slverr), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
